mario_wavrom_arbiter: RTL and testbench

//  Round-robin arbiter that shares the single-port sample (wave) ROM between up to NCH

---
 rtl/mario_wavrom_arbiter.sv | 101 ++++++++++
 tb/tb_mario_wavrom_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mario_wavrom_arbiter.sv
// Round-robin arbiter sharing the single-port wave ROM between sample-playback channels.
// Reads are pipelined; each returned word is tagged with its owning channel.
module mario_wavrom_arbiter #(
   parameter int NCH    = 4,
   parameter int AW     = 13,
   parameter int DW     = 16,
   parameter int RD_LAT = 1
) (
   input  logic              I_CLK_48M,
   input  logic              I_RESETn,
   input  logic [NCH-1:0]    I_REQ,
   input  logic [NCH*AW-1:0] I_ADDR,
   input  logic              I_DL_BUSY,
   output logic [NCH-1:0]    O_GNT,
   output logic [NCH-1:0]    O_ACK,
   output logic [DW-1:0]     O_DATA,
   output logic [AW-1:0]     O_ROM_ADDR,
   input  logic [DW-1:0]     I_ROM_DATA,
   output logic              O_BUSY
);

   localparam int PW = $clog2(NCH);

   typedef struct packed {
      logic          vld;
      logic [PW-1:0] ch;
   } tag_t;

   logic [PW-1:0]  ptr;
   logic [PW-1:0]  win;
   logic [PW-1:0]  ptr_nxt;
   logic [PW-1:0]  cand;
   logic [PW:0]    sum;
   logic [NCH-1:0] pend;
   logic [NCH-1:0] pend_nxt;
   logic [NCH-1:0] elig;
   logic [NCH-1:0] win_oh;
   logic           found;
   logic           busy_nxt;
   tag_t           tag [RD_LAT+1];

   // A channel being ACKed this cycle is already free to win again this cycle.
   assign elig = I_REQ & ~(pend & ~O_ACK) & {NCH{~I_DL_BUSY}};

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      cand  = '0;
      for (int i = 0; i < NCH; i++) begin
         sum = {1'b0, ptr} + (PW+1)'(i);
         if (sum >= (PW+1)'(NCH)) sum = sum - (PW+1)'(NCH);
         cand = sum[PW-1:0];
         if (!found && elig[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign ptr_nxt  = (win == PW'(NCH-1)) ? '0 : win + PW'(1);
   assign win_oh   = found ? (NCH'(1) << win) : '0;
   assign pend_nxt = (pend & ~O_ACK) | win_oh;

   always_comb begin
      busy_nxt = (|pend_nxt) | found;
      for (int i = 0; i < RD_LAT; i++) busy_nxt = busy_nxt | tag[i].vld;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge I_CLK_48M or negedge I_RESETn) begin
      if (!I_RESETn) begin
         ptr        <= '0;
         pend       <= '0;
         O_GNT      <= '0;
         O_ACK      <= '0;
         O_DATA     <= '0;
         O_ROM_ADDR <= '0;
         O_BUSY     <= 1'b0;
         // NOTE: the tag pipe is reset, so reads issued before reset never produce an ACK.
         for (int i = 0; i <= RD_LAT; i++) tag[i] <= '0;
      end else begin
         pend   <= pend_nxt;
         O_GNT  <= win_oh;
         O_BUSY <= busy_nxt;
         if (found) begin
            ptr        <= ptr_nxt;
            O_ROM_ADDR <= I_ADDR[win*AW +: AW];
         end
         tag[0] <= '{vld: found, ch: win};
         for (int i = 1; i <= RD_LAT; i++) tag[i] <= tag[i-1];
         O_ACK <= '0;
         if (tag[RD_LAT].vld) begin
            O_ACK  <= NCH'(1) << tag[RD_LAT].ch;
            O_DATA <= I_ROM_DATA;
         end
      end
   end

endmodule

// File: tb/tb_mario_wavrom_arbiter.sv
// Bench for mario_wavrom_arbiter: RD_LAT=1 and RD_LAT=3 instances against a queue-based
// scoreboard fed by an independent round-robin model.
module tb_mario_wavrom_arbiter;

   localparam int NCH = 4;
   localparam int AW  = 13;
   localparam int DW  = 16;

   typedef struct {
      int              gdue;
      int              due;
      int              ch;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              sel;
   logic [NCH-1:0]    req;
   logic              dl;
   logic [AW-1:0]     addr_v [NCH];
   logic [NCH*AW-1:0] addr_bus;

   logic [NCH-1:0] req1, req3, gnt1, gnt3, ack1, ack3;
   logic           dl1, dl3, busy1, busy3;
   logic [DW-1:0]  data1, data3, rdata1, rdata3;
   logic [AW-1:0]  raddr1, raddr3;
   logic [AW-1:0]  ap3 [2];

   logic [NCH-1:0] obs_gnt, obs_ack;
   logic [DW-1:0]  obs_data;
   logic [AW-1:0]  obs_raddr;
   logic           obs_busy;

   for (genvar c = 0; c < NCH; c++) begin : g_addr
      assign addr_bus[c*AW +: AW] = addr_v[c];
   end

   assign req1 = sel ? '0 : req;
   assign req3 = sel ? req : '0;
   assign dl1  = sel ? 1'b0 : dl;
   assign dl3  = sel ? dl : 1'b0;

   assign obs_gnt   = sel ? gnt3   : gnt1;
   assign obs_ack   = sel ? ack3   : ack1;
   assign obs_data  = sel ? data3  : data1;
   assign obs_raddr = sel ? raddr3 : raddr1;
   assign obs_busy  = sel ? busy3  : busy1;

   mario_wavrom_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
      .I_CLK_48M (clk),    .I_RESETn  (rst_n),  .I_REQ      (req1),
      .I_ADDR    (addr_bus), .I_DL_BUSY (dl1),  .O_GNT      (gnt1),
      .O_ACK     (ack1),   .O_DATA    (data1),  .O_ROM_ADDR (raddr1),
      .I_ROM_DATA(rdata1), .O_BUSY    (busy1)
   );

   mario_wavrom_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
      .I_CLK_48M (clk),    .I_RESETn  (rst_n),  .I_REQ      (req3),
      .I_ADDR    (addr_bus), .I_DL_BUSY (dl3),  .O_GNT      (gnt3),
      .O_ACK     (ack3),   .O_DATA    (data3),  .O_ROM_ADDR (raddr3),
      .I_ROM_DATA(rdata3), .O_BUSY    (busy3)
   );

   function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
      logic [DW-1:0] x;
      x = {{(DW-AW){1'b0}}, a};
      return (x * 16'd40503) ^ 16'hA5C3;
   endfunction

   // Wave ROM models with 1 and 3 cycles of read latency.
   always @(posedge clk) rdata1 <= rom_f(raddr1);
   always @(posedge clk) begin
      ap3[0] <= raddr3;
      ap3[1] <= ap3[0];
      rdata3 <= rom_f(ap3[1]);
   end

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            m_ptr;
   int            free_at [NCH];
   int            n_gnt [NCH];
   int            n_ack [NCH];
   logic [DW-1:0] m_data;
   exp_t          gq [$];
   exp_t          aq [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Model decides this cycle's winner from the driven inputs, then the edge, then compare.
   task automatic step();
      int   lat;
      int   w;
      bit   found;
      logic busy_exp;
      exp_t e;
      lat   = sel ? 3 : 1;
      found = 0;
      w     = 0;
      if (rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            int c;
            c = (m_ptr + i) % NCH;
            if (!found && req[c] && !dl && cyc >= free_at[c]) begin
               found = 1;
               w     = c;
            end
         end
         if (found) begin
            e.gdue = cyc + 1;
            e.due  = cyc + 2 + lat;
            e.ch   = w;
            e.addr = addr_v[w];
            e.data = rom_f(addr_v[w]);
            gq.push_back(e);
            aq.push_back(e);
            free_at[w] = cyc + 2 + lat;
            m_ptr      = (w + 1) % NCH;
            n_gnt[w]++;
         end
      end
      @(posedge clk);
      cyc++;
      #1;
      busy_exp = 1'b0;
      foreach (aq[i]) if (aq[i].gdue <= cyc) busy_exp = 1'b1;
      if (gq.size() > 0 && gq[0].gdue == cyc) begin
         e = gq.pop_front();
         check("gnt", 32'(obs_gnt), 32'(1) << e.ch);
         check("rom_addr", 32'(obs_raddr), 32'(e.addr));
      end else begin
         check("gnt_idle", 32'(obs_gnt), 32'd0);
      end
      if (aq.size() > 0 && aq[0].due == cyc) begin
         e = aq.pop_front();
         m_data = e.data;
         check("ack", 32'(obs_ack), 32'(1) << e.ch);
      end else begin
         check("ack_idle", 32'(obs_ack), 32'd0);
      end
      for (int c = 0; c < NCH; c++) if (obs_ack[c]) n_ack[c]++;
      check("data", 32'(obs_data), 32'(m_data));
      check("busy", 32'(obs_busy), 32'(busy_exp));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      gq.delete();
      aq.delete();
      m_ptr  = 0;
      m_data = '0;
      for (int c = 0; c < NCH; c++) free_at[c] = 0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      sel = 1'b0;
      req = '0;
      dl  = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         addr_v[c] = AW'(13'h0100 * (c + 1));
         n_gnt[c]  = 0;
         n_ack[c]  = 0;
      end
      do_reset();

      // Single request, RD_LAT=1: GNT one cycle later, ACK three cycles later.
      addr_v[1] = 13'h0800;
      req = 4'b0010;
      step();
      check("t1_gnt", 32'(obs_gnt), 32'h2);
      check("t1_rom_addr", 32'(obs_raddr), 32'h0800);
      req = '0;
      steps(2);
      check("t1_ack", 32'(obs_ack), 32'h2);
      check("t1_data", 32'(obs_data), 32'(rom_f(13'h0800)));
      steps(3);

      // All channels held from reset: 0,1,2,3 then rotating.
      req = 4'hF;
      do_reset();
      steps(14);
      req = '0;
      steps(5);

      // Two competing channels alternate.
      do_reset();
      req = 4'b0101;
      steps(12);
      req = '0;
      steps(5);

      // Download busy with two reads in flight: they complete, then arbitration resumes.
      do_reset();
      req = 4'b0011;
      steps(2);
      dl  = 1'b1;
      req = 4'hF;
      steps(8);
      dl = 1'b0;
      steps(8);
      req = '0;
      steps(5);

      // Reset one cycle after GNT[2]: no ACK, outputs cleared at once, ch2 regranted later.
      do_reset();
      addr_v[2] = 13'h1234;
      req = 4'b0100;
      step();
      req = '0;
      step();
      rst_n = 1'b0;
      #1;
      check("rst_gnt", 32'(obs_gnt), 32'd0);
      check("rst_ack", 32'(obs_ack), 32'd0);
      check("rst_data", 32'(obs_data), 32'd0);
      check("rst_rom_addr", 32'(obs_raddr), 32'd0);
      check("rst_busy", 32'(obs_busy), 32'd0);
      do_reset();
      steps(5);
      req = 4'b0100;
      step();
      check("t5_regnt", 32'(obs_gnt), 32'h4);
      req = '0;
      steps(5);

      // RD_LAT=3 random sweep.
      sel = 1'b1;
      do_reset();
      for (int c = 0; c < NCH; c++) begin
         n_gnt[c] = 0;
         n_ack[c] = 0;
      end
      for (int i = 0; i < 400; i++) begin
         req = NCH'($urandom_range(0, 15));
         dl  = ($urandom_range(0, 7) == 0);
         for (int c = 0; c < NCH; c++) addr_v[c] = AW'($urandom);
         step();
      end
      req = '0;
      dl  = 1'b0;
      steps(10);
      for (int c = 0; c < NCH; c++) check("ack_count", 32'(n_ack[c]), 32'(n_gnt[c]));
      check("gq_drained", 32'(gq.size()), 32'd0);
      check("aq_drained", 32'(aq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
